// File: rtl/des_scheduler_pkg.sv
// Shared constants for the DES engine scheduler: FSM state codes and default
// operand widths.
package des_scheduler_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_BUSY    = 2'd2;
   localparam logic [1:0] ST_DELIVER = 2'd3;

   localparam int DES_DATA_WIDTH = 64;
   localparam int DES_KEY_WIDTH  = 64;

endpackage

// File: rtl/des_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module des_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      pos   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         // One extra bit so the wrap works for non-power-of-two NUM_REQ.
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         pos = sum[IDX_W-1:0];
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/des_scheduler.sv
// Shares one DES engine among NUM_REQ requesters: round-robin grant, operand
// capture, start strobe, watchdog on the engine and result hand-back.
module des_scheduler
   import des_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = DES_DATA_WIDTH,
   parameter int KEY_WIDTH  = DES_KEY_WIDTH,
   parameter int TIMEOUT    = 31
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_din,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_din,
   input  logic [NUM_REQ*KEY_WIDTH-1:0]  req_key_din,
   output logic [NUM_REQ-1:0]            grant_dout,
   output logic                          start_strobe_dout,
   output logic [DATA_WIDTH-1:0]         data_dout,
   output logic [KEY_WIDTH-1:0]          key_dout,
   input  logic                          done_strobe_din,
   input  logic [DATA_WIDTH-1:0]         engine_result_din,
   output logic                          result_valid_dout,
   output logic [NUM_REQ-1:0]            result_owner_dout,
   output logic [DATA_WIDTH-1:0]         result_dout,
   output logic                          result_error_dout,
   input  logic                          result_ack_din,
   output logic                          busy_dout
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]            state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]      owner_idx_q, owner_idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [KEY_WIDTH-1:0]  key_q, key_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  error_q, error_d;

   logic [NUM_REQ-1:0]    arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_any;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [KEY_WIDTH-1:0]  sel_key;

   des_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req    (req_din),
      .rr_ptr (rr_ptr_q),
      .grant  (arb_grant),
      .idx    (arb_idx),
      .any    (arb_any)
   );

   always_comb begin
      sel_data = '0;
      sel_key  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_data = req_data_din[i*DATA_WIDTH +: DATA_WIDTH];
            sel_key  = req_key_din[i*KEY_WIDTH +: KEY_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      owner_idx_d = owner_idx_q;
      data_d      = data_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      error_d     = error_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               state_d     = ST_LOAD;
               owner_d     = arb_grant;
               owner_idx_d = arb_idx;
               data_d      = sel_data;
               key_d       = sel_key;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A done strobe on the watchdog's last cycle still counts as success.
            if (done_strobe_din) begin
               result_d = engine_result_din;
               error_d  = 1'b0;
               state_d  = ST_DELIVER;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               result_d = '0;
               error_d  = 1'b1;
               state_d  = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (result_ack_din) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (owner_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                               : owner_idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         owner_idx_q <= '0;
         data_q      <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         owner_idx_q <= owner_idx_d;
         data_q      <= data_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         error_q     <= error_d;
      end
   end

   assign grant_dout         = (state_q == ST_LOAD) ? owner_q : '0;
   assign start_strobe_dout  = (state_q == ST_LOAD);
   assign data_dout          = data_q;
   assign key_dout           = key_q;
   assign result_valid_dout  = (state_q == ST_DELIVER);
   assign result_owner_dout  = (state_q == ST_DELIVER) ? owner_q : '0;
   assign result_dout        = result_q;
   assign result_error_dout  = error_q && (state_q == ST_DELIVER);
   assign busy_dout          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_des_scheduler.sv
// Randomized bench for des_scheduler with a job-level reference model
// (round-robin pick by modular search, engine delay vs. watchdog window).
module tb_des_scheduler;

   localparam int NREQ    = 4;
   localparam int DW      = 64;
   localparam int KW      = 64;
   localparam int TIMEOUT = 31;
   localparam int NEVER   = 1000;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NREQ-1:0]      req_din = '0;
   logic [NREQ*DW-1:0]   req_data_din = '0;
   logic [NREQ*KW-1:0]   req_key_din = '0;
   logic [NREQ-1:0]      grant_dout;
   logic                 start_strobe_dout;
   logic [DW-1:0]        data_dout;
   logic [KW-1:0]        key_dout;
   logic                 done_strobe_din = 1'b0;
   logic [DW-1:0]        engine_result_din = '0;
   logic                 result_valid_dout;
   logic [NREQ-1:0]      result_owner_dout;
   logic [DW-1:0]        result_dout;
   logic                 result_error_dout;
   logic                 result_ack_din = 1'b0;
   logic                 busy_dout;

   int tests_run = 0;
   int tests_failed = 0;
   int rr_m = 0;

   des_scheduler #(
      .NUM_REQ    (NREQ),
      .DATA_WIDTH (DW),
      .KEY_WIDTH  (KW),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_din           (req_din),
      .req_data_din      (req_data_din),
      .req_key_din       (req_key_din),
      .grant_dout        (grant_dout),
      .start_strobe_dout (start_strobe_dout),
      .data_dout         (data_dout),
      .key_dout          (key_dout),
      .done_strobe_din   (done_strobe_din),
      .engine_result_din (engine_result_din),
      .result_valid_dout (result_valid_dout),
      .result_owner_dout (result_owner_dout),
      .result_dout       (result_dout),
      .result_error_dout (result_error_dout),
      .result_ack_din    (result_ack_din),
      .busy_dout         (busy_dout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
      for (int off = 0; off < NREQ; off++) begin
         if (r[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
      end
      return -1;
   endfunction

   task automatic randomize_operands();
      for (int i = 0; i < NREQ; i++) begin
         req_data_din[i*DW +: DW] = {$urandom, $urandom};
         req_key_din[i*KW +: KW]  = {$urandom, $urandom};
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_grant"}, grant_dout, 0);
      chk({tag, "_start"}, start_strobe_dout, 0);
      chk({tag, "_data"}, data_dout, 0);
      chk({tag, "_key"}, key_dout, 0);
      chk({tag, "_valid"}, result_valid_dout, 0);
      chk({tag, "_owner"}, result_owner_dout, 0);
      chk({tag, "_result"}, result_dout, 0);
      chk({tag, "_error"}, result_error_dout, 0);
      chk({tag, "_busy"}, busy_dout, 0);
   endtask

   // One full job. dly = cycles from start strobe to engine done (NEVER = no done).
   task automatic do_job(input logic [NREQ-1:0] req, input logic [63:0] win_data,
                         input logic [63:0] res, input int dly, input int ack_hold,
                         input bit hold_req, input bit scramble);
      int w;
      logic [63:0] ed, ek, er;
      bit got_done;
      w = pick(req, rr_m);
      randomize_operands();
      req_data_din[w*DW +: DW] = win_data;
      ed = win_data;
      ek = req_key_din[w*KW +: KW];
      req_din = req;
      step();
      chk("load_grant", grant_dout, 64'(1) << w);
      chk("load_start", start_strobe_dout, 1);
      chk("load_data", data_dout, ed);
      chk("load_key", key_dout, ek);
      chk("load_busy", busy_dout, 1);
      if (!hold_req) req_din = NREQ'($urandom);
      step();
      got_done = 1'b0;
      for (int c = 0; c <= TIMEOUT; c++) begin
         done_strobe_din   = (c == dly - 1);
         engine_result_din = (c == dly - 1) ? res : {$urandom, $urandom};
         result_ack_din    = scramble ? 1'($urandom) : 1'b0;
         if (scramble) randomize_operands();
         chk("busy_valid", result_valid_dout, 0);
         chk("busy_start", start_strobe_dout, 0);
         chk("busy_data_hold", data_dout, ed);
         chk("busy_key_hold", key_dout, ek);
         step();
         if (c == dly - 1) begin
            got_done = 1'b1;
            break;
         end
      end
      done_strobe_din = 1'b0;
      result_ack_din  = 1'b0;
      er = got_done ? res : 64'h0;
      for (int k = 0; k <= ack_hold; k++) begin
         chk("dlv_valid", result_valid_dout, 1);
         chk("dlv_owner", result_owner_dout, 64'(1) << w);
         chk("dlv_result", result_dout, er);
         chk("dlv_error", result_error_dout, !got_done);
         chk("dlv_busy", busy_dout, 1);
         if (k < ack_hold) begin
            done_strobe_din   = 1'($urandom);
            engine_result_din = {$urandom, $urandom};
            step();
            done_strobe_din = 1'b0;
         end
      end
      result_ack_din = 1'b1;
      step();
      result_ack_din = 1'b0;
      chk("ack_valid_drop", result_valid_dout, 0);
      chk("ack_idle", busy_dout, 0);
      rr_m = (w + 1) % NREQ;
      if (!hold_req) req_din = '0;
   endtask

   initial begin
      logic [NREQ-1:0] r;
      #2;
      check_all_zero("reset");
      #10;
      reset = 1'b1;
      step();
      check_all_zero("post_reset");

      // Done strobe while idle must be ignored.
      done_strobe_din = 1'b1;
      step();
      done_strobe_din = 1'b0;
      chk("idle_done_busy", busy_dout, 0);
      chk("idle_done_valid", result_valid_dout, 0);

      do_job(4'b0001, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 16, 0, 1'b0, 1'b0);

      for (int j = 0; j < 4; j++) begin
         do_job(4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 16, 0, 1'b1, 1'b0);
         chk("fair_owner_idx", rr_m, (j % 2 == 0) ? 2 : 0);
      end
      req_din = '0;

      do_job(4'b0010, {$urandom, $urandom}, {$urandom, $urandom}, NEVER, 1, 1'b0, 1'b0);
      do_job(4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, TIMEOUT + 1, 0, 1'b0, 1'b0);
      do_job(4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, 16, 10, 1'b0, 1'b1);

      for (int j = 0; j < 24; j++) begin
         do r = NREQ'($urandom); while (r == '0);
         do_job(r, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 1'b0, 1'b1);
      end

      // Asynchronous reset in the middle of BUSY.
      req_din = 4'b0010;
      step();
      req_din = '0;
      step();
      step();
      step();
      chk("pre_rst_busy", busy_dout, 1);
      #3;
      reset = 1'b0;
      #1;
      check_all_zero("async_rst");
      #2;
      reset = 1'b1;
      rr_m = 0;
      done_strobe_din   = 1'b1;
      engine_result_din = 64'hDEADBEEFCAFEF00D;
      step();
      done_strobe_din = 1'b0;
      chk("stray_done_busy", busy_dout, 0);
      chk("stray_done_valid", result_valid_dout, 0);
      step();
      chk("stray_done_result", result_dout, 0);
      do_job(4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, 16, 0, 1'b0, 1'b0);
      chk("post_rst_rr", rr_m, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
